// File: rtl/matrix_mult_ctrl.sv
// rtl/matrix_mult_ctrl.sv - register-file initiator computing C = A x B one cell at a time.
// Optional MATMUL_SATURATE_EN clamps each C cell to the signed CELL_WIDTH range instead of truncating.
module matrix_mult_ctrl #(
    parameter int SIZE          = 4,
    parameter int ADDRESS_WIDTH = 4,
    parameter int CELL_WIDTH    = 32,
    parameter int WIDTH         = CELL_WIDTH * SIZE
) (
    input  logic                     in_clk,
    input  logic                     in_reset,
    input  logic                     in_start,
    output logic                     out_busy,
    output logic                     out_done,
    output logic [ADDRESS_WIDTH-1:0] out_address,
    output logic [1:0]               out_type,
    output logic [1:0]               out_select_matrix,
    output logic                     out_read_en,
    output logic                     out_write_en,
    output logic [WIDTH-1:0]         out_data,
    input  logic [WIDTH-1:0]         in_data
);
    localparam int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int ACC_W = 2 * CELL_WIDTH + CNT_W;

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP_B, MAC, WR_C, DONE} state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         i_q, j_q, k_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [WIDTH-1:0]         row_a_q, col_b_q;

    logic signed [CELL_WIDTH-1:0]   a_elem, b_elem;
    logic signed [2*CELL_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        acc_d;
    logic [CELL_WIDTH-1:0]          result;
    logic                           i_last, j_last, k_last;

    always_comb begin
        a_elem = row_a_q[int'(k_q)*CELL_WIDTH +: CELL_WIDTH];
        b_elem = col_b_q[int'(k_q)*CELL_WIDTH +: CELL_WIDTH];
        prod   = a_elem * b_elem;
        acc_d  = acc_q + {{(ACC_W-2*CELL_WIDTH){prod[2*CELL_WIDTH-1]}}, prod};
        i_last = (i_q == CNT_W'(SIZE-1));
        j_last = (j_q == CNT_W'(SIZE-1));
        k_last = (k_q == CNT_W'(SIZE-1));
`ifdef MATMUL_SATURATE_EN
        // In range only when every bit above the cell's sign bit matches it.
        if (acc_d[ACC_W-1:CELL_WIDTH-1] == '0 || acc_d[ACC_W-1:CELL_WIDTH-1] == '1)
            result = acc_d[CELL_WIDTH-1:0];
        else if (acc_d[ACC_W-1])
            result = {1'b1, {(CELL_WIDTH-1){1'b0}}};
        else
            result = {1'b0, {(CELL_WIDTH-1){1'b1}}};
`else
        result = acc_d[CELL_WIDTH-1:0];
`endif
    end

    // Outputs are loaded on the edge that enters a state, so they line up with that state.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q           <= IDLE;
            i_q               <= '0;
            j_q               <= '0;
            k_q               <= '0;
            acc_q             <= '0;
            row_a_q           <= '0;
            col_b_q           <= '0;
            out_busy          <= 1'b0;
            out_done          <= 1'b0;
            out_address       <= '0;
            out_type          <= 2'b00;
            out_select_matrix <= 2'b00;
            out_read_en       <= 1'b0;
            out_write_en      <= 1'b0;
            out_data          <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_start) begin
                        state_q           <= RD_A;
                        i_q               <= '0;
                        j_q               <= '0;
                        out_busy          <= 1'b1;
                        out_read_en       <= 1'b1;
                        out_type          <= 2'b01;
                        out_select_matrix <= 2'b00;
                        out_address       <= '0;
                    end
                end
                RD_A: begin
                    state_q           <= RD_B;
                    out_read_en       <= 1'b1;
                    out_type          <= 2'b10;
                    out_select_matrix <= 2'b01;
                    out_address       <= ADDRESS_WIDTH'(j_q);
                end
                RD_B: begin
                    if (j_q == '0)
                        row_a_q <= in_data;
                    state_q           <= CAP_B;
                    out_read_en       <= 1'b0;
                    out_type          <= 2'b00;
                    out_select_matrix <= 2'b00;
                    out_address       <= '0;
                end
                CAP_B: begin
                    col_b_q <= in_data;
                    acc_q   <= '0;
                    k_q     <= '0;
                    state_q <= MAC;
                end
                MAC: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 1'b1;
                    if (k_last) begin
                        state_q           <= WR_C;
                        out_write_en      <= 1'b1;
                        out_type          <= 2'b00;
                        out_select_matrix <= 2'b10;
                        out_address       <= ADDRESS_WIDTH'(int'(i_q) * SIZE + int'(j_q));
                        out_data          <= {{(WIDTH-CELL_WIDTH){1'b0}}, result};
                    end
                end
                WR_C: begin
                    out_write_en <= 1'b0;
                    out_data     <= '0;
                    if (j_last) begin
                        j_q <= '0;
                        if (i_last) begin
                            state_q           <= DONE;
                            out_done          <= 1'b1;
                            out_type          <= 2'b00;
                            out_select_matrix <= 2'b00;
                            out_address       <= '0;
                        end else begin
                            i_q               <= i_q + 1'b1;
                            state_q           <= RD_A;
                            out_read_en       <= 1'b1;
                            out_type          <= 2'b01;
                            out_select_matrix <= 2'b00;
                            out_address       <= ADDRESS_WIDTH'((int'(i_q) + 1) * SIZE);
                        end
                    end else begin
                        j_q               <= j_q + 1'b1;
                        state_q           <= RD_B;
                        out_read_en       <= 1'b1;
                        out_type          <= 2'b10;
                        out_select_matrix <= 2'b01;
                        out_address       <= ADDRESS_WIDTH'(int'(j_q) + 1);
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    out_done <= 1'b0;
                    out_busy <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// tb/tb_matrix_mult_ctrl.sv - self-checking bench for matrix_mult_ctrl with a register-file model.
module tb_matrix_mult_ctrl;
    localparam int S  = 4;
    localparam int AW = 4;
    localparam int CW = 32;
    localparam int W  = CW * S;

    logic          clk = 1'b0;
    logic          reset, start;
    logic          busy, done, rd, wr;
    logic [AW-1:0] addr;
    logic [1:0]    typ, sel;
    logic [W-1:0]  data_o, data_i;

    matrix_mult_ctrl #(.SIZE(S), .ADDRESS_WIDTH(AW), .CELL_WIDTH(CW), .WIDTH(W)) dut (
        .in_clk(clk), .in_reset(reset), .in_start(start),
        .out_busy(busy), .out_done(done), .out_address(addr), .out_type(typ),
        .out_select_matrix(sel), .out_read_en(rd), .out_write_en(wr),
        .out_data(data_o), .in_data(data_i)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_a [S*S];
    logic [31:0] mem_b [S*S];
    logic [31:0] mem_c [S*S];
    logic        clr_c = 1'b0;

    function automatic logic [W-1:0] fetch(logic [1:0] s, logic [1:0] t, logic [AW-1:0] a);
        logic [W-1:0] v = '0;
        for (int k = 0; k < S; k++) begin
            int idx = (t == 2'b01) ? (int'(a) / S) * S + k : k * S + int'(a);
            v[k*CW +: CW] = (s == 2'b00) ? mem_a[idx] : mem_b[idx];
        end
        return v;
    endfunction

    // Register file: one-cycle read latency, garbage data when no read was issued.
    always @(posedge clk) begin
        if (rd) data_i <= fetch(sel, typ, addr);
        else    data_i <= {$urandom, $urandom, $urandom, $urandom};
        if (clr_c) begin
            for (int n = 0; n < S*S; n++) mem_c[n] <= 32'hDEADBEEF;
        end else if (wr && typ == 2'b00 && sel == 2'b10) begin
            mem_c[addr] <= data_o[31:0];
        end
    end

    int         n_writes, n_done, proto_err;
    logic [7:0] ev_q[$];
    always @(negedge clk) begin
        if (rd && wr) proto_err++;
        if (wr && data_o[W-1:CW] != '0) proto_err++;
        if (wr) n_writes++;
        if (done) n_done++;
        if (rd || wr) ev_q.push_back({typ, sel, addr});
    end

    int passed = 0, total = 0;
    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [31:0] ref_cell(int i, int j);
        logic signed [65:0] s = '0;
        for (int k = 0; k < S; k++)
            s += $signed(mem_a[i*S+k]) * $signed(mem_b[k*S+j]);
`ifdef MATMUL_SATURATE_EN
        if (s > 66'sd2147483647)       return 32'h7FFFFFFF;
        else if (s < -66'sd2147483648) return 32'h80000000;
`endif
        return s[31:0];
    endfunction

    task automatic clear_c();
        clr_c = 1'b1;
        @(negedge clk);
        clr_c = 1'b0;
    endtask

    task automatic run_mm(output int cyc);
        start = 1'b1;
        cyc = 0;
        while (cyc < 1000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = 1'b0;
            if (done) break;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic fill(logic [31:0] a, logic [31:0] b);
        for (int n = 0; n < S*S; n++) begin
            mem_a[n] = a;
            mem_b[n] = b;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_c;
    } vec_t;

    initial begin
        vec_t       vecs[6];
        int         cyc, d0, done_cyc, bad;
        logic [7:0] exp_ev[$];

        vecs[0] = '{32'd2,        32'd3,        32'h00000018};
        vecs[1] = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFC};
        vecs[2] = '{32'd0,        32'h12345678, 32'h00000000};
`ifdef MATMUL_SATURATE_EN
        vecs[3] = '{32'h40000000, 32'h40000000, 32'h7FFFFFFF};
        vecs[4] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF};
        vecs[5] = '{32'h80000000, 32'd1,        32'h80000000};
`else
        vecs[3] = '{32'h40000000, 32'h40000000, 32'h00000000};
        vecs[4] = '{32'h80000000, 32'h80000000, 32'h00000000};
        vecs[5] = '{32'h80000000, 32'd1,        32'h00000000};
`endif

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, addr, typ, sel, rd, wr, data_o}, '0);
        reset = 1'b0;
        @(negedge clk);

        // Identity x B: C must equal B, with the exact access sequence and latency.
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++) begin
                mem_a[r*S+c] = (r == c) ? 32'd1 : 32'd0;
                mem_b[r*S+c] = 32'(4*r + c + 1);
            end
        clear_c();
        n_writes = 0;
        proto_err = 0;
        ev_q.delete();
        run_mm(cyc);
        check("identity_latency", cyc, 117);
        check("identity_writes", n_writes, 16);
        for (int n = 0; n < S*S; n++) check("identity_c", mem_c[n], 32'(n + 1));
        for (int i = 0; i < S; i++) begin
            exp_ev.push_back({2'b01, 2'b00, 4'(i*S)});
            for (int j = 0; j < S; j++) begin
                exp_ev.push_back({2'b10, 2'b01, 4'(j)});
                exp_ev.push_back({2'b00, 2'b10, 4'(i*S+j)});
            end
        end
        check("access_count", ev_q.size(), exp_ev.size());
        bad = 0;
        for (int n = 0; n < exp_ev.size() && n < ev_q.size(); n++)
            if (ev_q[n] !== exp_ev[n]) bad++;
        check("access_sequence_errors", bad, 0);

        foreach (vecs[v]) begin
            fill(vecs[v].a, vecs[v].b);
            clear_c();
            run_mm(cyc);
            check("uniform_latency", cyc, 117);
            for (int n = 0; n < S*S; n++) check("uniform_c", mem_c[n], vecs[v].exp_c);
        end

        fill(32'd0, 32'd0);
        mem_a[0] = 32'hFFFFFFFF;
        for (int c = 0; c < S; c++) mem_b[c] = 32'd5;
        clear_c();
        run_mm(cyc);
        for (int n = 0; n < S*S; n++)
            check("neg_row_c", mem_c[n], (n < S) ? 32'hFFFFFFFB : 32'h0);

        for (int t = 0; t < 4; t++) begin
            for (int n = 0; n < S*S; n++) begin
                mem_a[n] = (t < 2) ? $urandom_range(0, 2000) - 1000 : $urandom;
                mem_b[n] = (t < 2) ? $urandom_range(0, 2000) - 1000 : $urandom;
            end
            clear_c();
            run_mm(cyc);
            for (int i = 0; i < S; i++)
                for (int j = 0; j < S; j++)
                    check("random_c", mem_c[i*S+j], ref_cell(i, j));
        end

        // Reset in the middle of a run, then a clean rerun.
        fill(32'd2, 32'd3);
        start = 1'b1;
        repeat (50) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("midreset_strobes", {busy, rd, wr, done}, 4'b0);
        reset = 1'b0;
        clear_c();
        run_mm(cyc);
        check("after_reset_latency", cyc, 117);
        for (int n = 0; n < S*S; n++) check("after_reset_c", mem_c[n], 32'h18);

        // Start pulses while busy must be ignored.
        d0 = n_done;
        done_cyc = 0;
        start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done && done_cyc == 0) done_cyc = c;
            start = (c < 110 && c % 7 == 0) ? 1'b1 : 1'b0;
        end
        check("busy_start_done_count", n_done - d0, 1);
        check("busy_start_latency", done_cyc, 117);
        check("protocol_errors", proto_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
